// File: rtl/uart_tx_fifo_sender.sv
// Buffered 16x-oversampled UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_sender #(
   parameter int DBITS      = 8,
   parameter int SBITS      = 1,
   parameter int BAUD_DIV   = 325,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [DBITS-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             busy,
   output logic             tx_done,
   output logic             tx
);

   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int CW         = (BAUD_DIV > 0) ? $clog2(BAUD_DIV + 1) : 1;
   localparam int STOP_TICKS = SBITS * 16;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state_reg, state_next;
   logic [CW-1:0]     tick_cnt_reg;
   logic [4:0]        s_reg, s_next;
   logic [2:0]        n_reg, n_next;
   logic [DBITS-1:0]  shift_reg, shift_next;
   logic              tx_reg, tx_next;
   logic              overflow_reg;
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic [DBITS-1:0]  mem [FIFO_DEPTH];
   logic [DBITS-1:0]  head;
   logic              tick, push, pop, done;
`ifdef UART_TX_PARITY_EN
   logic              parity_reg, parity_next;
`endif

   assign full     = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count_reg == '0);
   assign overflow = overflow_reg;
   assign busy     = (state_reg != IDLE);
   assign tx_done  = done;
   assign tx       = tx_reg;
   assign tick     = (tick_cnt_reg == CW'(BAUD_DIV));
   assign push     = wr_en && !full;
   assign head     = mem[rd_ptr_reg];

   // Storage has no reset: resetting the pointers and count discards its contents.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         tick_cnt_reg <= '0;
         s_reg        <= '0;
         n_reg        <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         overflow_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         s_reg        <= s_next;
         n_reg        <= n_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         overflow_reg <= wr_en && full;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= parity_next;
`endif
         // Held at zero in IDLE so every start bit gets its full 16 ticks.
         if (state_reg == IDLE || tick)
            tick_cnt_reg <= '0;
         else
            tick_cnt_reg <= tick_cnt_reg + CW'(1);
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      state_next  = state_reg;
      s_next      = s_reg;
      n_next      = n_reg;
      shift_next  = shift_reg;
      pop         = 1'b0;
      done        = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop         = 1'b1;
               shift_next  = head;
`ifdef UART_TX_PARITY_EN
               parity_next = ^head;
`endif
               s_next      = '0;
               n_next      = '0;
               state_next  = START;
            end
         end
         START: begin
            if (tick) begin
               if (s_reg == 5'd15) begin
                  s_next     = '0;
                  n_next     = '0;
                  state_next = DATA;
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_reg == 5'd15) begin
                  s_next     = '0;
                  shift_next = shift_reg >> 1;
                  if (n_reg == 3'(DBITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     state_next = PARITY;
`else
                     state_next = STOP;
`endif
                  end else begin
                     n_next = n_reg + 3'd1;
                  end
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (s_reg == 5'd15) begin
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (s_reg == 5'(STOP_TICKS - 1)) begin
                  done   = 1'b1;
                  s_next = '0;
                  // Chain straight into the next start bit while bytes are queued.
                  if (!empty) begin
                     pop         = 1'b1;
                     shift_next  = head;
`ifdef UART_TX_PARITY_EN
                     parity_next = ^head;
`endif
                     n_next      = '0;
                     state_next  = START;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + 5'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Line level follows the state being entered so tx stays aligned with state_reg.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo_sender.sv
// Scoreboard bench for uart_tx_fifo_sender: accepted bytes are queued, a line monitor decodes tx and pops.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_sender;

   localparam int DBITS      = 8;
   localparam int SBITS      = 1;
   localparam int BAUD_DIV   = 1;
   localparam int FIFO_DEPTH = 8;
   localparam int BIT_CLKS   = 16 * (BAUD_DIV + 1);
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_CLKS = (2 + DBITS + SBITS) * BIT_CLKS;
`else
   localparam int FRAME_CLKS = (1 + DBITS + SBITS) * BIT_CLKS;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             wr_en;
   logic [DBITS-1:0] wr_data;
   logic             full, empty, overflow, busy, tx_done, tx;

   int               tests = 0;
   int               failed = 0;
   int               done_cnt = 0;
   int               exp_done = 0;
   logic [DBITS-1:0] sb [$];

   uart_tx_fifo_sender #(
      .DBITS(DBITS), .SBITS(SBITS), .BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .overflow(overflow), .busy(busy),
      .tx_done(tx_done), .tx(tx)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drive one write for a single edge; the caller states whether the FIFO should accept it.
   task automatic write_byte(input logic [DBITS-1:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) begin
         sb.push_back(d);
         exp_done++;
      end
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         if (tx_done === 1'b1) return;
         step(1);
      end
      check("done_timeout", tx_done, 1);
   endtask

   always @(negedge clock) begin
      if (!reset && tx_done === 1'b1) done_cnt++;
   end

   task automatic mon_wait(input int n, output bit hit);
      hit = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (reset) begin
            hit = 1'b1;
            break;
         end
      end
   endtask

   // Line monitor: finds a start bit and samples every bit near its centre.
   initial begin : monitor
      logic [DBITS-1:0] rx_byte;
      logic [DBITS-1:0] exp_byte;
      logic             start_lvl, stop_lvl, par_lvl;
      bit               abort, h;
      forever begin
         @(negedge clock);
         if (!reset && tx === 1'b0) begin
            abort   = 1'b0;
            rx_byte = '0;
            par_lvl = 1'b0;
            mon_wait(BIT_CLKS / 2 - 1, h);
            abort     = h;
            start_lvl = tx;
            for (int i = 0; i < DBITS && !abort; i++) begin
               mon_wait(BIT_CLKS, h);
               abort      = h;
               rx_byte[i] = tx;
            end
`ifdef UART_TX_PARITY_EN
            if (!abort) begin
               mon_wait(BIT_CLKS, h);
               abort   = h;
               par_lvl = tx;
            end
`endif
            if (!abort) begin
               mon_wait(BIT_CLKS, h);
               abort = h;
            end
            stop_lvl = tx;
            if (abort) begin
               $display("[TB] frame abandoned by reset");
            end else begin
               check("start_bit", {31'd0, start_lvl}, 32'd0);
               check("stop_bit", {31'd0, stop_lvl}, 32'd1);
               if (sb.size() == 0) begin
                  check("spurious_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
               end else begin
                  exp_byte = sb.pop_front();
                  $display("[TB] rx byte %02h (expected %02h)", rx_byte, exp_byte);
                  check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_byte});
`ifdef UART_TX_PARITY_EN
                  check("parity_bit", {31'd0, par_lvl}, {31'd0, ^exp_byte});
`endif
               end
            end
         end
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge clock);
      $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [DBITS-1:0] msg [8];
      msg = '{8'h43, 8'h6F, 8'h6E, 8'h74, 8'h72, 8'h6F, 8'h6C, 8'h0A};
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      step(3);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      reset = 1'b0;
      step(2);

      // Single byte with exact start latency and tx_done placement.
      write_byte(8'h55, 1'b1);
      check("single_empty_after_wr", empty, 0);
      check("single_tx_before_start", tx, 1);
      step(1);
      check("single_tx_start", tx, 0);
      check("single_busy", busy, 1);
      step(FRAME_CLKS - 2);
      check("single_done_early", tx_done, 0);
      step(1);
      check("single_done_pulse", tx_done, 1);
      check("single_tx_stop", tx, 1);
      step(1);
      check("single_done_end", tx_done, 0);
      check("single_busy_end", busy, 0);
      check("single_empty_end", empty, 1);
      step(5);

      // Burst of three: each stop must run straight into the next start bit.
      write_byte(8'h52, 1'b1);
      write_byte(8'h65, 1'b1);
      write_byte(8'h61, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wait_done();
         step(1);
         if (k < 2) begin
            check("burst_b2b_tx", tx, 0);
            check("burst_b2b_busy", busy, 1);
            if (k == 1) check("burst_empty_after_pop3", empty, 1);
         end else begin
            check("burst_idle_busy", busy, 0);
            check("burst_idle_tx", tx, 1);
         end
      end
      step(5);

      // Message stream.
      for (int i = 0; i < 8; i++) write_byte(msg[i], 1'b1);
      check("msg_not_full", full, 0);
      for (int i = 0; i < 8; i++) begin
         wait_done();
         step(1);
      end
      check("msg_empty", empty, 1);
      step(5);

      // Fill the FIFO while a frame is on the line, then overflow it once.
      write_byte(8'hC3, 1'b1);
      step(4);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         write_byte(8'h10 + 8'(i), 1'b1);
         if (i == FIFO_DEPTH - 2) check("fill_not_full", full, 0);
      end
      check("fill_full", full, 1);
      check("fill_no_overflow", overflow, 0);
      write_byte(8'hEE, 1'b0);
      check("ovf_pulse", overflow, 1);
      check("ovf_still_full", full, 1);
      step(1);
      check("ovf_pulse_end", overflow, 0);
      for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
         wait_done();
         step(1);
      end
      check("fill_drained", empty, 1);
      step(5);

      // Reset in the middle of data bit 3 of 0xA5.
      write_byte(8'hA5, 1'b1);
      step(1 + BIT_CLKS + 3 * BIT_CLKS + BIT_CLKS / 2);
      check("rst_mid_bit3", tx, 0);
      reset = 1'b1;
      exp_done -= sb.size();
      sb.delete();
      step(1);
      check("rst_mid_tx", tx, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_empty", empty, 1);
      reset = 1'b0;
      step(2);
      write_byte(8'h0F, 1'b1);
      wait_done();
      step(1);
      check("post_rst_idle", busy, 0);
      step(5);

`ifdef UART_TX_PARITY_EN
      write_byte(8'h07, 1'b1);
      write_byte(8'h03, 1'b1);
      for (int k = 0; k < 2; k++) begin
         wait_done();
         step(1);
      end
      step(5);
`endif

      check("sb_drained", sb.size(), 0);
      check("done_count", done_cnt, exp_done);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_sender.md
Name: uart_tx_fifo_sender

Overview:
- Buffered UART transmitter; the transmit-side counterpart to the 16x-oversampled uart_system_receiver.
- Uses the same oversampling tick scheme (16 ticks per bit) and the same DBITS/SBITS framing parameters, so matched instances interoperate.
- Accepts bytes through a write-only FIFO (e.g. "Ready\n" or "Control\n" message bytes from the top-level control FSM).
- Serialises frames LSB-first with back-to-back streaming and no idle gap while the FIFO holds data.

Parameters:
- DBITS, 8: data bits per frame (5..8).
- SBITS, 1: stop bits per frame (1 or 2).
- BAUD_DIV, 325: oversample tick asserted once every BAUD_DIV+1 clocks; one bit = 16 ticks.
- FIFO_DEPTH, 8: FIFO entries; power of two, at least 2.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- wr_en, input, 1: write strobe; accepted when full=0.
- wr_data, input, DBITS: byte to enqueue.
- full, output, 1: FIFO count == FIFO_DEPTH.
- empty, output, 1: FIFO count == 0.
- overflow, output, 1: 1-cycle pulse when wr_en is asserted while full.
- busy, output, 1: FSM not in IDLE.
- tx_done, output, 1: 1-cycle pulse on the last clock of each stop period.
- tx, output, 1: serial line, registered, idle high.

Behaviour:
- Reset: tx=1, busy=0, tx_done=0, overflow=0, full=0, empty=1; FIFO pointers, count, tick counter, bit counters = 0; state=IDLE.
- Reset mid-frame: the frame is abandoned, tx=1 on the next edge, and FIFO contents are discarded.
- Interface clocking: all outputs are registered or decoded from registers. Clock and reset are exactly as stated under Ports: reset is synchronous, active-high; the clock is clock.
- Tick generator: counter runs 0..BAUD_DIV and wraps; tick=1 when counter==BAUD_DIV. The counter is held at 0 while in IDLE so the start bit is always full length.
- FIFO: circular buffer with count of width clog2(FIFO_DEPTH)+1.
  - Write when wr_en && !full.
  - Write while full is dropped and raises overflow. This holds even if a pop occurs in the same cycle, because full is evaluated before the pop.
  - Simultaneous push and pop when not full and not empty: count unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE: if !empty, pop the head entry into shift_reg and go to START. tx is driven 0 from the next edge.
- START: tx=0. After 16 ticks, go to DATA with bit count n=0.
- DATA: tx=shift_reg[0]. Every 16 ticks, shift right; n increments. After n==DBITS-1 completes, go to STOP (or to PARITY if enabled).
- STOP: tx=1 for SBITS*16 ticks. On the final tick, pulse tx_done. Then:
  - if !empty: pop the next entry and go directly to START (no idle bit);
  - otherwise go to IDLE.
- Latency: wr_en at edge N into an empty FIFO in IDLE gives count=1 at N+1 and tx=0 at N+2.
- Frame length: (1+DBITS+SBITS)*16*(BAUD_DIV+1) clocks, plus 16 ticks if parity is enabled.
- Writes during transmission are accepted normally. The in-flight frame is unaffected, because its byte already lives in shift_reg.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA. tx = even parity (XOR of the DBITS data bits) for 16 ticks, then STOP. The matching receiver must also expect parity.
- Undefined: no PARITY state; the frame goes straight from DATA to STOP.

Test Plan:
- Single byte, BAUD_DIV=1 (32 clk/bit), write 0x55 -> tx=0 at N+2 for 32 clk, then bits 1,0,1,0,1,0,1,0 at 32 clk each, stop high 32 clk; tx_done pulses once; total frame 320 clk.
- Burst: write 0x52,0x65,0x61 on consecutive cycles -> three frames back-to-back with no idle gap between stop and start bits; exactly 3 tx_done pulses; empty=1 after the 3rd pop.
- FIFO full: FIFO_DEPTH=8, write 9 bytes while a frame is in progress.
  - full=1 after the write that fills the last slot.
  - Any write while full is dropped and pulses overflow.
  - Output order is preserved: only accepted bytes are transmitted, in write order.
- Loopback: connect tx to uart_system_receiver (DBITS=8, SBITS=1, matching tick rate), send "Control\n" -> the receiver emits 8 rx_done pulses with data 0x43,0x6F,0x6E,0x74,0x72,0x6F,0x6C,0x0A.
- Reset mid-frame: assert reset during the DATA bit 3 of 0xA5 -> tx=1 next edge, empty=1, busy=0; a following write of 0x0F transmits a clean full frame.
- UART_TX_PARITY_EN defined, write 0x07 -> parity bit=1 after data; write 0x03 -> parity bit=0; frame is 11 bits (352 clk at BAUD_DIV=1).
